// File: rtl/iob_split_reg_pkg.sv
// iob_split_reg_pkg
//  Shared definitions for the IOb splitter: FSM state encodings, the default
//  error-response data word, the error-counter width and a saturating
//  increment helper.
//  Optional feature macro used by the top: IOB_SPLIT_TIMEOUT_EN.
package iob_split_reg_pkg;

    localparam int          ERR_CNT_W    = 16;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // The counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/iob_split_dec.sv
// iob_split_dec
//  Combinational slave decode: extracts the select field
//  addr[SEL_MSB -: SEL_W] and flags whether it names an existing slave.
// Ports
//  addr    in   ADDR_W   master byte address
//  sel     out  SEL_W    raw select field
//  mapped  out  1        sel < N_SLAVES
module iob_split_dec
    import iob_split_reg_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int SEL_MSB  = ADDR_W - 2,
    parameter int SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  sel,
    output logic              mapped
);

    // Only the select field matters here; the rest of the address is
    // consumed by the slaves through the registered s_addr.
    logic unused_addr;

    assign sel         = addr[SEL_MSB -: SEL_W];
    assign mapped      = (32'(sel) < 32'(N_SLAVES));
    assign unused_addr = ^addr;

endmodule

// File: rtl/iob_split_reg.sv
// iob_split_reg
//  N-way IOb native-bus splitter. A master request is registered in IDLE,
//  the address select field picks one slave, and that slave's response is
//  routed straight back to the master in the cycle it arrives. Selects that
//  name no slave produce a one-cycle error response (ERR_DATA, err pulse)
//  and bump a saturating error counter.
//  Optional feature: define IOB_SPLIT_TIMEOUT_EN to abort a BUSY access
//  that sees no s_ready within TIMEOUT cycles (turned into an error
//  response). Without it BUSY waits indefinitely.
// Ports
//  clk, rst              clock (rising), async active-low reset
//  m_valid/addr/wdata/wstrb   master request (wstrb 0 = read)
//  m_rdata, m_ready      master response; m_rdata is 0 while m_ready=0
//  s_valid               one-hot slave request
//  s_addr/wdata/wstrb    registered request, shared by all slaves
//  s_rdata, s_ready      per-slave response data / pulse
//  err, err_cnt          error pulse and saturating error count
module iob_split_reg
    import iob_split_reg_pkg::*;
#(
    parameter int                 N_SLAVES = 4,
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 SEL_MSB  = ADDR_W - 2,
    parameter int                 SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
    parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(ERR_DATA_DEF),
    parameter int                 TIMEOUT  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_valid,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic [N_SLAVES-1:0]          s_valid,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]          s_ready,
    output logic                         err,
    output logic [ERR_CNT_W-1:0]         err_cnt
);

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [N_SLAVES-1:0]    s_valid_q, s_valid_d;
    logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
    logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
    logic [DATA_W/8-1:0]    s_wstrb_q, s_wstrb_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

`ifdef IOB_SPLIT_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
`endif

    logic [SEL_W-1:0]       dec_sel;
    logic                   dec_mapped;
    logic [N_SLAVES-1:0]    dec_onehot;
    logic                   sel_ready;
    logic [DATA_W-1:0]      sel_rdata;
    logic                   m_ready_c;
    logic [DATA_W-1:0]      m_rdata_c;
    logic                   err_c;

    iob_split_dec #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W),
        .SEL_MSB  (SEL_MSB),
        .SEL_W    (SEL_W)
    ) u_dec (
        .addr     (m_addr),
        .sel      (dec_sel),
        .mapped   (dec_mapped)
    );

    // One-hot request vector for the slave being captured this cycle.
    always_comb begin
        dec_onehot = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            dec_onehot[i] = (dec_sel == SEL_W'(i));
        end
    end

    // Response mux: only the selected slave's ready/data are looked at, so
    // stray s_ready pulses from other slaves never reach the master.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        s_valid_d = s_valid_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wstrb_d = s_wstrb_q;
        err_cnt_d = err_cnt_q;
`ifdef IOB_SPLIT_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        m_ready_c = 1'b0;
        m_rdata_c = '0;
        err_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m_valid) begin
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    s_wstrb_d = m_wstrb;
                    sel_d     = dec_sel;
                    if (dec_mapped) begin
                        state_d   = ST_BUSY;
                        s_valid_d = dec_onehot;
`ifdef IOB_SPLIT_TIMEOUT_EN
                        to_cnt_d  = '0;
`endif
                    end else begin
                        state_d   = ST_ERR;
                    end
                end
            end

            ST_BUSY: begin
                // Response is passed through in the cycle it arrives.
                if (sel_ready) begin
                    m_ready_c = 1'b1;
                    m_rdata_c = sel_rdata;
                    state_d   = ST_IDLE;
                    s_valid_d = '0;
`ifdef IOB_SPLIT_TIMEOUT_EN
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // A ready in this same cycle would have won above.
                    state_d   = ST_ERR;
                    s_valid_d = '0;
                end else begin
                    to_cnt_d  = to_cnt_q + TO_W'(1);
`endif
                end
            end

            ST_ERR: begin
                m_ready_c = 1'b1;
                m_rdata_c = ERR_DATA;
                err_c     = 1'b1;
                err_cnt_d = sat_inc(err_cnt_q);
                state_d   = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                s_valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            s_valid_q <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            err_cnt_q <= '0;
`ifdef IOB_SPLIT_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            s_valid_q <= s_valid_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
            err_cnt_q <= err_cnt_d;
`ifdef IOB_SPLIT_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    assign s_valid = s_valid_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_wstrb = s_wstrb_q;
    assign err_cnt = err_cnt_q;
    assign m_ready = m_ready_c;
    assign m_rdata = m_rdata_c;
    assign err     = err_c;

endmodule

// File: tb/tb_iob_split_reg.sv
// tb_iob_split_reg
//  Scoreboard bench for iob_split_reg with 3 slaves, select field
//  m_addr[31:30], TIMEOUT=8. Expected responses are queued when a request
//  is issued and popped by a monitor whenever m_ready is seen.
//  The timeout scenario runs only when IOB_SPLIT_TIMEOUT_EN is defined.
module tb_iob_split_reg;

    logic        clk;
    logic        rst;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic [2:0]  s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [95:0] s_rdata;
    logic [2:0]  s_ready;
    logic        err;
    logic [15:0] err_cnt;

    logic [31:0] d0, d1, d2;
    int          slv_wait [3];
    logic [2:0]  slv_silent;
    logic        stray;
    logic        late_rdy;
    int          wcnt [3];

    logic [32:0] sb_q [$];
    int          n_chk;
    int          n_fail;

    iob_split_reg #(
        .N_SLAVES (3),
        .ADDR_W   (32),
        .DATA_W   (32),
        .SEL_MSB  (31),
        .SEL_W    (2),
        .ERR_DATA (32'hDEADBEEF),
        .TIMEOUT  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .s_ready (s_ready),
        .err     (err),
        .err_cnt (err_cnt)
    );

    assign s_rdata = {d2, d1, d0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave models: ready after slv_wait[i] extra cycles, sampled just after
    // the active edge so a zero-wait slave answers in the s_valid cycle.
    always begin
        @(posedge clk);
        #1;
        s_ready = '0;
        if (late_rdy) begin
            s_ready = 3'b010;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!s_valid[i]) begin
                    wcnt[i] = 0;
                end else if (!slv_silent[i]) begin
                    if (wcnt[i] == slv_wait[i]) begin
                        s_ready[i] = 1'b1;
                        wcnt[i]    = 0;
                    end else begin
                        wcnt[i]++;
                    end
                end
            end
        end
        if (stray && s_valid[2]) s_ready[0] = 1'b1;
    end

    // Response monitor / scoreboard pop.
    always @(negedge clk) begin
        logic [32:0] e;
        if (m_ready === 1'b1) begin
            chk("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("rsp_rdata", m_rdata, e[31:0]);
                chk("rsp_err", err, e[32]);
            end
        end else if (rst) begin
            chk("idle_rdata", m_rdata, 0);
            chk("idle_err", err, 0);
        end
    end

    // Issue one request at posedge+1, check the registered request in the
    // s_valid cycle, wait (bounded) for m_ready, then drop m_valid.
    task automatic xact(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] exp_rd, input logic exp_e,
                        input logic [2:0] exp_sv, input int exp_lat);
        int lat;
        sb_q.push_back({exp_e, exp_rd});
        m_addr  = a;
        m_wdata = wd;
        m_wstrb = ws;
        m_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lat = 1;
        chk({tag, "_svalid"}, s_valid, exp_sv);
        chk({tag, "_saddr"}, s_addr, a);
        chk({tag, "_swdata"}, s_wdata, wd);
        chk({tag, "_swstrb"}, s_wstrb, ws);
        while (m_ready !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_ready_seen"}, m_ready, 1'b1);
        if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b0;
        m_valid    = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_wstrb    = '0;
        s_ready    = '0;
        d0         = 32'h0000_AAAA;
        d1         = 32'h1234_5678;
        d2         = 32'h2222_2222;
        slv_wait   = '{0, 2, 0};
        slv_silent = '0;
        stray      = 1'b0;
        late_rdy   = 1'b0;
        wcnt       = '{0, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_svalid", s_valid, 0);
        chk("rst_mready", m_ready, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_mrdata", m_rdata, 0);
        chk("rst_errcnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1. read from slave1 with two wait cycles
        xact("t1", 32'h4000_0010, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3'b010, 3);

        // 2. zero-wait write to slave0
        xact("t2", 32'h0000_0004, 32'hA5A5_A5A5, 4'hF, 32'h0000_AAAA, 1'b0, 3'b001, 1);

        // 3. unmapped select
        xact("t3", 32'hC000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 3'b000, 1);
        chk("t3_errcnt", err_cnt, 16'd1);

        // 4. back-to-back 0, 2, 1 with a stray s_ready[0] during slave2
        slv_wait = '{0, 1, 2};
        stray    = 1'b1;
        xact("t4a", 32'h0000_0100, 32'h11, 4'h1, 32'h0000_AAAA, 1'b0, 3'b001, 1);
        xact("t4b", 32'h8000_0200, 32'h22, 4'h3, 32'h2222_2222, 1'b0, 3'b100, 3);
        xact("t4c", 32'h4000_0300, 32'h33, 4'h0, 32'h1234_5678, 1'b0, 3'b010, 2);
        stray    = 1'b0;
        chk("t4_errcnt", err_cnt, 16'd1);

`ifdef IOB_SPLIT_TIMEOUT_EN
        // 6a. silent slave2 times out 8 cycles after s_valid rises
        slv_silent = 3'b100;
        xact("t6", 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 3'b100, 9);
        slv_silent = 3'b000;
        chk("t6_errcnt", err_cnt, 16'd2);
`endif

        // 5. reset while BUSY, then a late s_ready must not respond
        slv_silent = 3'b010;
        m_addr  = 32'h4000_0040;
        m_wdata = 32'h0;
        m_wstrb = 4'h0;
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_busy_svalid", s_valid, 3'b010);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_valid = 1'b0;
        #1;
        chk("t5_rst_svalid", s_valid, 0);
        chk("t5_rst_saddr", s_addr, 0);
        chk("t5_rst_swstrb", s_wstrb, 0);
        chk("t5_rst_mready", m_ready, 0);
        chk("t5_rst_mrdata", m_rdata, 0);
        chk("t5_rst_err", err, 0);
        chk("t5_rst_errcnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        slv_silent = 3'b000;
        @(negedge clk);
        late_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_late_mready", m_ready, 0);
            chk("t5_late_svalid", s_valid, 0);
        end
        late_rdy = 1'b0;
        @(posedge clk);
        #1;

        // 6b. saturation of the error counter
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.err_cnt_q;
        chk("sat_pre", err_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        xact("sat", 32'hC000_0004, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 3'b000, 1);
        chk("sat_post", err_cnt, 16'hFFFF);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
